// File: rtl/rle_compress_handler_pkg.sv
// rle_compress_handler_pkg: shared widths, run limit, first-run value and FSM encoding for the RLE compressor
package rle_compress_handler_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int RUN_W = 8;
  localparam int RUN_MAX = (1 << RUN_W) - 1;
  localparam logic FIRST_RUN_VAL = 1'b0;
  typedef enum logic [2:0] {IDLE, FETCH, SCAN, FLUSH, DONE} state_t;
endpackage

// File: rtl/rle_compress_handler_if.sv
// rle_compress_handler_if: command, DMA read and packed-output signals; enc_bytes exists only with COMPRESS_STATS_EN
interface rle_compress_handler_if;
  import rle_compress_handler_pkg::*;
  logic start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] word_count;
  logic [ADDR_W-1:0] ram_addr;
  logic ram_read;
  logic [DATA_W-1:0] ram_data_in;
  logic ram_done_read;
  logic [DATA_W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic busy;
  logic done;
`ifdef COMPRESS_STATS_EN
  logic [31:0] enc_bytes;
`endif
  modport master(
    output start, base_addr, word_count, ram_data_in, ram_done_read, out_ready,
    input ram_addr, ram_read, out_data, out_valid, busy, done
`ifdef COMPRESS_STATS_EN
    , input enc_bytes
`endif
  );
  modport slave(
    input start, base_addr, word_count, ram_data_in, ram_done_read, out_ready,
    output ram_addr, ram_read, out_data, out_valid, busy, done
`ifdef COMPRESS_STATS_EN
    , output enc_bytes
`endif
  );
endinterface

// File: rtl/rle_compress_handler_packer.sv
// rle_byte_packer: packs run bytes high-then-low into words, pads a lone high byte on flush, valid/ready output
module rle_byte_packer
  import rle_compress_handler_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [RUN_W-1:0]  byte_i,
  input  logic              flush_i,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  output logic              ready_o,
  output logic              drain_o
);
  logic [RUN_W-1:0] hi_q, hi_d;
  logic half_q, half_d, valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  always_comb begin
    hi_d = hi_q;
    half_d = half_q;
    valid_d = valid_q && !out_ready_i;
    data_d = data_q;
    if (!valid_q && push_i) begin
      if (half_q) begin
        data_d = {hi_q, byte_i};
        valid_d = 1'b1;
        half_d = 1'b0;
      end else begin
        hi_d = byte_i;
        half_d = 1'b1;
      end
    end else if (!valid_q && flush_i && half_q) begin
      data_d = {hi_q, {RUN_W{1'b0}}};
      valid_d = 1'b1;
      half_d = 1'b0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q <= '0;
      half_q <= 1'b0;
      valid_q <= 1'b0;
      data_q <= '0;
    end else begin
      hi_q <= hi_d;
      half_q <= half_d;
      valid_q <= valid_d;
      data_q <= data_d;
    end
  end
  assign out_data_o = data_q;
  assign out_valid_o = valid_q;
  assign ready_o = !valid_q;
  // drained: nothing buffered once any pending word is taken this cycle
  assign drain_o = !half_q && (!valid_q || out_ready_i);
endmodule

// File: rtl/rle_compress_handler.sv
// rle_compress_handler: reads RAM words over DMA, run-length encodes bits MSB-first, streams packed run bytes.
// Optional COMPRESS_STATS_EN adds the enc_bytes emitted-byte counter.
module rle_compress_handler
  import rle_compress_handler_pkg::*;
(
  input logic clk_i,
  input logic rst_ni,
  rle_compress_handler_if.slave bus_if
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, wc_q, wc_d, idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [3:0] bit_q, bit_d;
  logic [RUN_W-1:0] cnt_q, cnt_d, byte_v;
  logic cur_q, cur_d, pz_q, pz_d, rd_q, rd_d;
  logic push, flush, pk_ready, pk_drain;
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    wc_d = wc_q;
    idx_d = idx_q;
    word_d = word_q;
    bit_d = bit_q;
    cnt_d = cnt_q;
    cur_d = cur_q;
    pz_d = pz_q;
    rd_d = rd_q;
    push = 1'b0;
    byte_v = '0;
    flush = 1'b0;
    // the zero half of a RUN_MAX split goes out as soon as the packer has room
    if (pz_q && pk_ready) begin
      push = 1'b1;
      pz_d = 1'b0;
    end
    case (state_q)
      IDLE: if (bus_if.start) begin
        base_d = bus_if.base_addr;
        wc_d = bus_if.word_count;
        idx_d = '0;
        cnt_d = '0;
        cur_d = FIRST_RUN_VAL;
        pz_d = 1'b0;
        state_d = (bus_if.word_count == '0) ? DONE : FETCH;
      end
      FETCH: begin
        if (!rd_q && pk_ready) rd_d = 1'b1;
        else if (rd_q && bus_if.ram_done_read) begin
          rd_d = 1'b0;
          word_d = bus_if.ram_data_in;
          bit_d = '0;
          idx_d = idx_q + 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: if (pk_ready && !pz_q) begin
        word_d = word_q << 1;
        bit_d = bit_q + 1'b1;
        if (word_q[DATA_W-1] != cur_q) begin
          push = 1'b1;
          byte_v = cnt_q;
          cur_d = ~cur_q;
          cnt_d = RUN_W'(1);
        end else if (cnt_q == RUN_W'(RUN_MAX)) begin
          push = 1'b1;
          byte_v = cnt_q;
          pz_d = 1'b1;
          cnt_d = RUN_W'(1);
        end else cnt_d = cnt_q + 1'b1;
        if (bit_q == 4'd15) state_d = (idx_q == wc_q) ? FLUSH : FETCH;
      end
      FLUSH: if (!pz_q) begin
        // cnt is at least 1 on entry, so zero marks the final run as already emitted
        if (cnt_q != '0) begin
          if (pk_ready) begin
            push = 1'b1;
            byte_v = cnt_q;
            cnt_d = '0;
          end
        end else begin
          flush = 1'b1;
          if (pk_drain) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      base_q <= '0;
      wc_q <= '0;
      idx_q <= '0;
      word_q <= '0;
      bit_q <= '0;
      cnt_q <= '0;
      cur_q <= FIRST_RUN_VAL;
      pz_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      wc_q <= wc_d;
      idx_q <= idx_d;
      word_q <= word_d;
      bit_q <= bit_d;
      cnt_q <= cnt_d;
      cur_q <= cur_d;
      pz_q <= pz_d;
      rd_q <= rd_d;
    end
  end
  rle_byte_packer u_packer (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .push_i(push),
    .byte_i(byte_v),
    .flush_i(flush),
    .out_ready_i(bus_if.out_ready),
    .out_data_o(bus_if.out_data),
    .out_valid_o(bus_if.out_valid),
    .ready_o(pk_ready),
    .drain_o(pk_drain)
  );
  assign bus_if.ram_addr = base_q + idx_q;
  assign bus_if.ram_read = rd_q;
  assign bus_if.busy = (state_q != IDLE) && (state_q != DONE);
  assign bus_if.done = (state_q == DONE);
`ifdef COMPRESS_STATS_EN
  logic [31:0] enc_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) enc_q <= '0;
    else enc_q <= (state_q == IDLE && bus_if.start) ? '0 : enc_q + {31'd0, push};
  end
  assign bus_if.enc_bytes = enc_q;
`endif
endmodule
